// File: rtl/stq_pkg.sv
// Store-queue dispatch allocator: shared sizes and index/count types.
// Index arithmetic relies on STQ_DEPTH being a power of two.
package stq_pkg;

  localparam int DISPATCH_WIDTH = 4;
  localparam int STQ_DEPTH      = 32;
  localparam int STQ_LOG        = $clog2(STQ_DEPTH);
  localparam int COMMIT_WIDTH   = 2;
  localparam int CNT_W          = $clog2(DISPATCH_WIDTH) + 1;
  localparam int CMT_W          = $clog2(COMMIT_WIDTH) + 1;

  typedef logic [STQ_LOG-1:0] stq_idx_t;
  typedef logic [STQ_LOG:0]   stq_cnt_t;

endpackage

// File: rtl/stq_dispatch_alloc_if.sv
// Dispatch/commit/flush inputs and allocation/occupancy outputs of the STQ allocator.
// The allocator takes the slave side; the driver of dispatch groups takes the master side.
interface stq_dispatch_alloc_if;
  import stq_pkg::*;

  logic                              dispValid_i;
  logic [DISPATCH_WIDTH-1:0]         instStore_i;
  logic [CMT_W-1:0]                  commitCnt_i;
  logic                              flush_i;
  logic                              stall_o;
  logic                              dispFire_o;
  logic [CNT_W-1:0]                  cntStNew_o;
  logic [DISPATCH_WIDTH*STQ_LOG-1:0] stqId_o;
  logic [DISPATCH_WIDTH*STQ_LOG-1:0] lastSt_o;
  logic [DISPATCH_WIDTH-1:0]         lastStValid_o;
  stq_idx_t                          stqHead_o;
  stq_idx_t                          stqTail_o;
  stq_cnt_t                          stqCount_o;
  logic                              commitErr_o;

  modport slave (
    input  dispValid_i, instStore_i, commitCnt_i, flush_i,
    output stall_o, dispFire_o, cntStNew_o, stqId_o, lastSt_o, lastStValid_o,
           stqHead_o, stqTail_o, stqCount_o, commitErr_o
  );

  modport master (
    output dispValid_i, instStore_i, commitCnt_i, flush_i,
    input  stall_o, dispFire_o, cntStNew_o, stqId_o, lastSt_o, lastStValid_o,
           stqHead_o, stqTail_o, stqCount_o, commitErr_o
  );

endinterface

// File: rtl/stq_prefix_alloc.sv
// Combinational per-slot STQ index assignment, youngest-older-store lookup and store popcount.
// Zero latency; no backpressure of its own.
module stq_prefix_alloc
  import stq_pkg::*;
(
  input  stq_idx_t                          i_tail,
  input  stq_idx_t                          i_head,
  input  stq_cnt_t                          i_count,
  input  logic [DISPATCH_WIDTH-1:0]         i_inst_store,
  output logic [DISPATCH_WIDTH*STQ_LOG-1:0] o_stq_id,
  output logic [DISPATCH_WIDTH*STQ_LOG-1:0] o_last_st,
  output logic [DISPATCH_WIDTH-1:0]         o_last_valid,
  output logic [CNT_W-1:0]                  o_cnt_new
);

  logic [CNT_W-1:0] w_pre;
  stq_idx_t         w_off;

  always_comb begin
    o_stq_id     = '0;
    o_last_st    = '0;
    o_last_valid = '0;
    w_pre        = '0;
    w_off        = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      w_off = i_tail + stq_idx_t'(w_pre);
      if (i_inst_store[k]) begin
        o_stq_id[k*STQ_LOG +: STQ_LOG] = w_off;
      end
      // w_pre counts only slots 0..k-1, so a slot never sees its own store
      if (w_pre != '0) begin
        o_last_st[k*STQ_LOG +: STQ_LOG] = w_off - stq_idx_t'(1);
        o_last_valid[k]                 = 1'b1;
      end else if (i_count != '0) begin
        o_last_st[k*STQ_LOG +: STQ_LOG] = i_tail - stq_idx_t'(1);
        o_last_valid[k]                 = 1'b1;
      end else begin
        o_last_st[k*STQ_LOG +: STQ_LOG] = i_head;
      end
      w_pre = w_pre + CNT_W'(i_inst_store[k]);
    end
    o_cnt_new = w_pre;
  end

endmodule

// File: rtl/stq_dispatch_alloc.sv
// STQ head/tail/count owner: stalls dispatch when space is short, retires commits, recovers on flush.
// Allocation outputs are combinational; head/tail/count/error register on the next clk edge.
module stq_dispatch_alloc
  import stq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  stq_dispatch_alloc_if.slave  stq
);

  stq_idx_t         r_head;
  stq_idx_t         r_tail;
  stq_cnt_t         r_count;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_new;
  stq_cnt_t         w_free;
  stq_cnt_t         w_commit_req;
  stq_cnt_t         w_commit_eff;
  stq_cnt_t         w_add;
  logic             w_commit_ill;
  logic             w_stall;
  logic             w_fire;
  stq_idx_t         w_head_nxt;

  stq_prefix_alloc u_prefix (
    .i_tail       (r_tail),
    .i_head       (r_head),
    .i_count      (r_count),
    .i_inst_store (stq.instStore_i),
    .o_stq_id     (stq.stqId_o),
    .o_last_st    (stq.lastSt_o),
    .o_last_valid (stq.lastStValid_o),
    .o_cnt_new    (w_cnt_new)
  );

  // Free space deliberately ignores this cycle's commit to keep the stall path short
  assign w_free       = stq_cnt_t'(STQ_DEPTH) - r_count;
  assign w_stall      = stq.dispValid_i & (stq_cnt_t'(w_cnt_new) > w_free);
  assign w_fire       = stq.dispValid_i & ~w_stall & ~stq.flush_i;

  assign w_commit_req = stq_cnt_t'(stq.commitCnt_i);
  assign w_commit_ill = w_commit_req > r_count;
  assign w_commit_eff = w_commit_ill ? r_count : w_commit_req;
  assign w_add        = w_fire ? stq_cnt_t'(w_cnt_new) : '0;
  assign w_head_nxt   = r_head + stq_idx_t'(w_commit_eff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_head <= w_head_nxt;
      r_err  <= r_err | w_commit_ill;
      if (stq.flush_i) begin
        r_tail  <= w_head_nxt;
        r_count <= '0;
      end else begin
        r_tail  <= r_tail + stq_idx_t'(w_add);
        r_count <= r_count - w_commit_eff + w_add;
      end
    end
  end

  assign stq.stall_o     = w_stall;
  assign stq.dispFire_o  = w_fire;
  assign stq.cntStNew_o  = w_cnt_new;
  assign stq.stqHead_o   = r_head;
  assign stq.stqTail_o   = r_tail;
  assign stq.stqCount_o  = r_count;
  assign stq.commitErr_o = r_err;

endmodule

// File: tb/tb_stq_dispatch_alloc.sv
// Directed bench for stq_dispatch_alloc: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_stq_dispatch_alloc;
  import stq_pkg::*;

  typedef struct {
    string       name;
    bit          c_ctl;
    bit          c_idx;
    bit          c_st;
    logic        stall;
    logic        fire;
    logic [2:0]  cnt;
    logic [19:0] id;
    logic [19:0] last;
    logic [3:0]  lv;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [5:0]  count;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  exp_t me;

  stq_dispatch_alloc_if bus();

  stq_dispatch_alloc dut (
    .clk   (clk),
    .reset (rst_n),
    .stq   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic exp_t blank(input string n);
    exp_t e;
    e.name = n; e.c_ctl = 0; e.c_idx = 0; e.c_st = 0;
    e.stall = 0; e.fire = 0; e.cnt = 0; e.id = 0; e.last = 0; e.lv = 0;
    e.head = 0; e.tail = 0; e.count = 0; e.err = 0;
    return e;
  endfunction

  function automatic exp_t w_ctl(input exp_t e, input logic s, input logic f, input int c);
    e.c_ctl = 1; e.stall = s; e.fire = f; e.cnt = 3'(c);
    return e;
  endfunction

  function automatic exp_t w_idx(input exp_t e, input logic [19:0] id, input logic [19:0] last,
                                 input logic [3:0] lv);
    e.c_idx = 1; e.id = id; e.last = last; e.lv = lv;
    return e;
  endfunction

  function automatic exp_t w_st(input exp_t e, input int h, input int t, input int c, input logic er);
    e.c_st = 1; e.head = 5'(h); e.tail = 5'(t); e.count = 6'(c); e.err = er;
    return e;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic [3:0] s, input logic [1:0] c, input logic f,
                      input exp_t e);
    @(posedge clk);
    #1;
    bus.dispValid_i = d;
    bus.instStore_i = s;
    bus.commitCnt_i = c;
    bus.flush_i     = f;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      if (me.c_ctl) begin
        chk(me.name, "stall", 32'(bus.stall_o), 32'(me.stall));
        chk(me.name, "fire", 32'(bus.dispFire_o), 32'(me.fire));
        chk(me.name, "cntNew", 32'(bus.cntStNew_o), 32'(me.cnt));
      end
      if (me.c_idx) begin
        chk(me.name, "stqId", 32'(bus.stqId_o), 32'(me.id));
        chk(me.name, "lastSt", 32'(bus.lastSt_o), 32'(me.last));
        chk(me.name, "lastStValid", 32'(bus.lastStValid_o), 32'(me.lv));
      end
      if (me.c_st) begin
        chk(me.name, "head", 32'(bus.stqHead_o), 32'(me.head));
        chk(me.name, "tail", 32'(bus.stqTail_o), 32'(me.tail));
        chk(me.name, "count", 32'(bus.stqCount_o), 32'(me.count));
        chk(me.name, "err", 32'(bus.commitErr_o), 32'(me.err));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cyc;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.dispValid_i = 0; bus.instStore_i = 0; bus.commitCnt_i = 0; bus.flush_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(0, 4'b0000, 0, 0, w_st(w_idx(w_ctl(blank("reset_idle"), 0, 0, 0),
         pk(0,0,0,0), pk(0,0,0,0), 4'b0000), 0, 0, 0, 0));
    step(1, 4'b1011, 0, 0, w_st(w_idx(w_ctl(blank("alloc_1011"), 0, 1, 3),
         pk(0,1,0,2), pk(0,0,1,1), 4'b1110), 0, 0, 0, 0));
    step(0, 4'b0000, 0, 0, w_st(w_idx(w_ctl(blank("after_alloc"), 0, 0, 0),
         pk(0,0,0,0), pk(2,2,2,2), 4'b1111), 0, 3, 3, 0));

    // Walk head/tail round to tail=30, count=5
    for (int i = 0; i < 11; i++) step(1, 4'b1111, 2, 0, blank("setup"));
    step(0, 4'b0000, 2, 0, w_st(blank("mid_walk"), 22, 15, 25, 0));
    step(0, 4'b0000, 1, 1, w_st(blank("pre_flush1"), 24, 15, 23, 0));
    step(1, 4'b1111, 0, 0, w_st(blank("post_flush1"), 25, 25, 0, 0));
    step(1, 4'b0001, 0, 0, blank("setup"));

    step(1, 4'b1111, 0, 0, w_st(w_idx(w_ctl(blank("wrap"), 0, 1, 4),
         pk(30,31,0,1), pk(29,30,31,0), 4'b1111), 25, 30, 5, 0));
    step(0, 4'b0000, 0, 0, w_st(w_idx(blank("after_wrap"),
         pk(0,0,0,0), pk(1,1,1,1), 4'b1111), 25, 2, 9, 0));

    for (int i = 0; i < 5; i++) step(1, 4'b1111, 0, 0, blank("setup"));
    step(1, 4'b0001, 0, 0, blank("setup"));
    step(1, 4'b0111, 2, 0, w_st(w_ctl(blank("stall"), 1, 0, 3), 25, 23, 30, 0));
    step(0, 4'b0000, 0, 0, w_st(blank("after_stall"), 27, 23, 28, 0));
    step(1, 4'b1111, 0, 0, w_ctl(blank("fill_exact"), 0, 1, 4));
    step(1, 4'b0000, 0, 0, w_st(w_ctl(blank("full_nostore"), 0, 1, 0), 27, 27, 32, 0));
    step(1, 4'b1000, 0, 0, w_st(w_idx(w_ctl(blank("full_store"), 1, 0, 1),
         pk(0,0,0,27), pk(26,26,26,26), 4'b1111), 27, 27, 32, 0));

    // Drain to head=4, then rebuild tail=10, count=6
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 2, 0, blank("setup"));
    step(0, 4'b0000, 1, 0, w_st(blank("drain"), 3, 27, 24, 0));
    step(0, 4'b0000, 0, 1, w_st(blank("pre_flush2"), 4, 27, 23, 0));
    step(1, 4'b1111, 0, 0, w_st(blank("post_flush2"), 4, 4, 0, 0));
    step(1, 4'b0011, 0, 0, blank("setup"));
    step(1, 4'b1111, 1, 1, w_st(w_idx(w_ctl(blank("flush"), 0, 0, 4),
         pk(10,11,12,13), pk(9,10,11,12), 4'b1111), 4, 10, 6, 0));
    step(0, 4'b0000, 0, 0, w_st(w_idx(w_ctl(blank("after_flush"), 0, 0, 0),
         pk(0,0,0,0), pk(5,5,5,5), 4'b0000), 5, 5, 0, 0));

    step(1, 4'b0001, 0, 0, blank("setup"));
    step(0, 4'b0000, 2, 0, w_st(blank("ill_commit"), 5, 6, 1, 0));
    step(0, 4'b0000, 0, 0, w_st(blank("after_ill"), 6, 6, 0, 1));
    step(0, 4'b0000, 0, 0, w_st(blank("err_sticky"), 6, 6, 0, 1));

    step(1, 4'b1111, 0, 0, blank("setup"));
    step(1, 4'b0111, 0, 0, blank("setup"));
    step(0, 4'b0000, 0, 0, w_st(blank("pre_areset"), 6, 13, 7, 1));
    step(0, 4'b0000, 0, 0, w_st(w_idx(w_ctl(blank("areset"), 0, 0, 0),
         pk(0,0,0,0), pk(0,0,0,0), 4'b0000), 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 4'b0000, 0, 0, w_st(blank("post_areset"), 0, 0, 0, 0));

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stq_dispatch_alloc.md
Name: stq_dispatch_alloc

Overview:
Parametrised store-queue allocator and occupancy tracker for the dispatch stage. It owns the STQ head, tail and count registers. Each cycle it assigns STQ indices to up to DISPATCH_WIDTH dispatching stores and computes, per slot, the youngest older store (with a valid flag). It stalls dispatch on insufficient space, retires committed stores, and recovers on flush.

Parameters:
DISPATCH_WIDTH, 4, instructions per dispatch group
STQ_DEPTH, 32, store-queue entries; must be a power of two
STQ_LOG, 5, log2(STQ_DEPTH)
COMMIT_WIDTH, 2, maximum stores retired per cycle

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
dispValid_i  in  1  dispatch group valid this cycle
instStore_i  in  DISPATCH_WIDTH  bit k set: slot k is a store
commitCnt_i  in  log2(COMMIT_WIDTH)+1  stores retiring from head this cycle
flush_i  in  1  squash all uncommitted stores
stall_o  out  1  group needs more entries than are free
dispFire_o  out  1  dispValid_i & ~stall_o & ~flush_i
cntStNew_o  out  log2(DISPATCH_WIDTH)+1  popcount(instStore_i)
stqId_o  out  DISPATCH_WIDTH*STQ_LOG  per-slot allocated index; 0 for non-store slots
lastSt_o  out  DISPATCH_WIDTH*STQ_LOG  per-slot index of youngest older store
lastStValid_o  out  DISPATCH_WIDTH  per-slot: an older store exists
stqHead_o  out  STQ_LOG  registered head
stqTail_o  out  STQ_LOG  registered tail (next free entry)
stqCount_o  out  STQ_LOG+1  registered occupancy
commitErr_o  out  1  sticky: commitCnt_i > stqCount_o was seen

Behaviour:
- Reset (asynchronous, reset=0): head=0, tail=0, count=0, commitErr_o=0. Combinational outputs then follow from the reset state.
- stqId_o, lastSt_o, lastStValid_o, stall_o, cntStNew_o and dispFire_o are combinational from current registers and inputs (zero latency). Head, tail and count update at the next rising edge.
- Allocation: let p_k = number of stores in slots 0..k-1. Store slot k gets stqId = (tail + p_k) mod STQ_DEPTH.
- lastSt, slot k:
  - If p_k>0: (tail + p_k - 1) mod STQ_DEPTH, valid=1.
  - Else if count>0: (tail-1) mod STQ_DEPTH, valid=1.
  - Else: lastSt=head, valid=0.
  - The slot's own store is never included; this applies to store and non-store slots alike.
- Free space: free = STQ_DEPTH - count, using the registered count. The same-cycle commit is not credited.
- stall_o = dispValid_i & (cntStNew_o > free). Stall is independent of flush_i.
- Normal update:
  - head += commitCnt_i
  - tail += dispFire_o ? cntStNew_o : 0
  - count = count - commitCnt_i + (dispFire_o ? cntStNew_o : 0)
  - All index arithmetic wraps mod STQ_DEPTH. Count never wraps.
- Flush update (flush_i=1): head += commitCnt_i; tail = new head; count = 0. Dispatch is suppressed.
- Illegal commit (commitCnt_i > count): set commitErr_o (sticky until reset). Clamp the effective commit to count, so head advances by count only.
- Dispatch with zero stores: dispFire_o may be 1; tail and count are unchanged.
- Full queue (count=STQ_DEPTH): any group containing a store stalls. A store-free group does not stall.
- Wrap-around: index STQ_DEPTH-1 is followed by 0, both inside a group and for lastSt when tail=0.
- Reset asserted mid-operation: all state clears immediately, regardless of clk.

Decomposition:
- Package stq_pkg holds:
  - STQ_DEPTH, STQ_LOG, DISPATCH_WIDTH, COMMIT_WIDTH
  - typedef stq_idx_t (STQ_LOG bits)
  - typedef stq_cnt_t (STQ_LOG+1 bits)
- Sub-module stq_prefix_alloc holds the combinational logic: prefix counts p_k, stqId, lastSt/lastStValid and popcount from tail, head, count and instStore_i.
- The top level holds the registers, stall/fire logic, commit clamp and error flag.

Test Plan:
- Reset, then instStore_i=4'b1011, dispValid_i=1 → stqId0=0, stqId1=1, stqId3=2; lastStValid=4'b1110; lastSt1=0, lastSt2=1, lastSt3=1. Next cycle tail=3, count=3.
- Wrap: tail=30, count=5, instStore_i=4'b1111 → stqIds 30, 31, 0, 1; lastSt0=29 (valid). Next cycle tail=2, count=9.
- Full/stall: count=30, instStore_i=4'b0111, commitCnt_i=2 → stall_o=1, tail unchanged; count becomes 28 (commit not credited to the stall decision).
- Flush with commit: head=4, tail=10, count=6, flush_i=1, commitCnt_i=1 → next cycle head=5, tail=5, count=0; dispFire_o=0.
- Illegal commit: count=1, commitCnt_i=2 → commitErr_o=1 and stays 1; head advances by 1; count=0.
- Asynchronous reset: drop reset between clock edges while count=7 → head, tail and count read 0 immediately with no clock edge; commitErr_o=0.
